// File: rtl/muldiv_iter_unit_if.sv
// muldiv_iter_unit_if: handshake and data bundle between the EX stage and
// the iterative multiply/divide unit.
//   master (EX side):  drives start/op_div/op_signed/ina/inb/annul,
//                      hi_we/lo_we/hilo_wdata; reads status and HI/LO.
//   slave  (unit):     drives busy/done/stallreq/div_by_zero/hi/lo.
interface muldiv_iter_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             op_div;
    logic             op_signed;
    logic [WIDTH-1:0] ina;
    logic [WIDTH-1:0] inb;
    logic             annul;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hilo_wdata;
    logic             busy;
    logic             done;
    logic             stallreq;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op_div, op_signed, ina, inb, annul, hi_we, lo_we, hilo_wdata,
        input  busy, done, stallreq, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op_div, op_signed, ina, inb, annul, hi_we, lo_we, hilo_wdata,
        output busy, done, stallreq, div_by_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_iter_unit.sv
// muldiv_iter_unit: iterative multiply/divide engine with HI/LO state.
// One result bit per cycle: shift-add multiply, restoring divide.
// Ports:
//   clk     - clock, all state changes on the rising edge
//   resetn  - asynchronous active-low reset
//   bus     - muldiv_iter_unit_if.slave: start/op/operands, annul, direct
//             HI/LO writes in; busy, done, stallreq, div_by_zero, hi, lo out
module muldiv_iter_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               resetn,
    muldiv_iter_unit_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;     // mult: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   opnd;    // multiplicand or divisor magnitude
    logic               is_div;
    logic               neg_q;   // product / quotient sign
    logic               neg_r;   // remainder sign
    logic               dbz;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic sgn);
        return (sgn && x[WIDTH-1]) ? -x : x;
    endfunction

    // One multiply step: add multiplicand when the current multiplier bit is
    // set, then shift the whole accumulator right.
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nx;
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

    // One restoring divide step: shift in the next dividend bit, subtract
    // the divisor when it fits. With a zero divisor every step "fits", so the
    // quotient becomes all-ones and the remainder ends up holding |ina|.
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] div_nx;
    assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign div_ge   = div_sh >= {1'b0, opnd};
    assign div_diff = div_sh[WIDTH-1:0] - opnd;
    assign div_nx   = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc[WIDTH-2:0], div_ge};

    logic [2*WIDTH-1:0] acc_nx;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    assign acc_nx = is_div ? div_nx : mul_nx;
    assign prod   = neg_q ? -acc_nx : acc_nx;
    // Divide-by-zero keeps the raw all-ones quotient; the sign-restored
    // remainder then equals the original dividend.
    assign quo    = (neg_q && !dbz) ? -acc_nx[WIDTH-1:0] : acc_nx[WIDTH-1:0];
    assign rem    = neg_r ? -acc_nx[2*WIDTH-1:WIDTH] : acc_nx[2*WIDTH-1:WIDTH];

    logic last;
    assign last = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dbz    <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.hi_we) hi_r <= bus.hilo_wdata;
                    if (bus.lo_we) lo_r <= bus.hilo_wdata;
                    if (bus.start && !bus.annul) begin
                        state  <= CALC;
                        cnt    <= '0;
                        is_div <= bus.op_div;
                        neg_q  <= bus.op_signed & (bus.ina[WIDTH-1] ^ bus.inb[WIDTH-1]);
                        neg_r  <= bus.op_signed & bus.ina[WIDTH-1];
                        dbz    <= bus.op_div & (bus.inb == '0);
                        if (bus.op_div) begin
                            acc  <= {{WIDTH{1'b0}}, magnitude(bus.ina, bus.op_signed)};
                            opnd <= magnitude(bus.inb, bus.op_signed);
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, magnitude(bus.inb, bus.op_signed)};
                            opnd <= magnitude(bus.ina, bus.op_signed);
                        end
                    end
                end
                CALC: begin
                    if (bus.annul) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        cnt <= cnt + 1'b1;
                        if (last) begin
                            state <= DONE;
                            if (is_div) begin
                                hi_r <= rem;
                                lo_r <= quo;
                            end else begin
                                {hi_r, lo_r} <= prod;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy        = (state != IDLE);
    // A late annul cannot undo the HI/LO write but still hides the pulse.
    assign bus.done        = (state == DONE) && !bus.annul;
    assign bus.stallreq    = ((state == IDLE) && bus.start && !bus.annul) || (state == CALC);
    assign bus.div_by_zero = dbz;
    assign bus.hi          = hi_r;
    assign bus.lo          = lo_r;

endmodule

// File: doc/muldiv_iter_unit.md
Name: muldiv_iter_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO state, instantiated inside the EX stage.
- Replaces the separate fixed-32-bit mul/div blocks with one engine: one op type, start/done handshake, annul, and a stall request into the stall controller.
- Supports signed and unsigned MULT/DIV, plus MTHI/MTLO-style direct HI/LO writes.
- HI/LO are held internally and read combinationally by EX for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op_div  in  1  1 = divide, 0 = multiply; sampled with start.
- op_signed  in  1  1 = two's-complement operands; sampled with start.
- ina  in  WIDTH  multiplicand / dividend.
- inb  in  WIDTH  multiplier / divisor.
- annul  in  1  abort the in-flight operation (flush).
- hi_we  in  1  direct HI write (MTHI).
- lo_we  in  1  direct LO write (MTLO).
- hilo_wdata  in  WIDTH  data for hi_we/lo_we.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse; HI/LO already hold the new result.
- stallreq  out  1  combinational stall request to the stall controller.
- div_by_zero  out  1  registered flag for the last divide; valid while done = 1.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (resetn = 0, asynchronous): state = IDLE; counter, internal accumulators, hi, lo = 0; done, div_by_zero, busy = 0.
- FSM states:
  - IDLE: on start = 1, capture operands and op; go to CALC with counter = 0.
  - CALC: one iteration per cycle. When counter == WIDTH-1, write the result into hi/lo and go to DONE.
  - DONE: done = 1 for this cycle only; next edge goes to IDLE.
- Latency: start sampled at edge k gives done = 1 in the cycle after edge k+WIDTH, i.e. WIDTH+1 cycles after start.
- stallreq = (state == IDLE & start & ~annul) | (state == CALC). It is 0 in DONE so the pipeline advances on the done cycle.
- Signed handling: convert operands to magnitudes on capture.
  - Product sign = sign(ina) ^ sign(inb).
  - Quotient sign = sign(ina) ^ sign(inb); remainder sign = sign(ina).
  - Most-negative operands must give correct two's-complement results (e.g. -2^31 * -1 = 2^31 as a 64-bit result).
- Multiply: shift-add, one multiplier bit per cycle. {hi, lo} = 2*WIDTH-bit product.
- Divide: restoring shift-subtract, one quotient bit per cycle. lo = quotient, hi = remainder.
- Divide by zero: still takes the full latency. Result lo = all-ones, hi = ina (raw input). div_by_zero = 1 for that result; cleared on the next start.
- annul:
  - Any state other than IDLE goes to IDLE at the next edge; hi/lo unchanged; no done pulse.
  - annul in DONE is too late: hi/lo are already written, but done is still suppressed.
  - annul with start in IDLE: start is ignored.
- Direct writes (hi_we/lo_we):
  - Honoured only in IDLE; ignored in CALC and DONE.
  - If asserted in IDLE together with start, the write is applied and the operation also launches; its result later overwrites hi/lo.
- start while busy is ignored; no queueing.
- Operands are captured on start; later changes to ina/inb have no effect.

Test Plan:
- Unsigned multiply: WIDTH=32, ina=0xFFFFFFFF, inb=0xFFFFFFFF, op_div=0, op_signed=0 -> done in cycle 33 after start; hi=0xFFFFFFFE, lo=0x00000001; stallreq high for cycles 0..32.
- Signed divide: ina=-7 (0xFFFFFFF9), inb=2, op_div=1, op_signed=1 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat unsigned -> lo=0x7FFFFFFC, hi=1.
- Signed most-negative multiply: ina=0x80000000, inb=0xFFFFFFFF, signed -> hi=0x00000000, lo=0x80000000.
- Divide by zero: ina=0x1234, inb=0 -> lo=0xFFFFFFFF, hi=0x1234, div_by_zero=1 during done.
- Annul mid-divide: preload hi=0xA, lo=0xB via hi_we/lo_we; start divide; annul at cycle 10 -> IDLE next edge, no done, hi=0xA, lo=0xB; hi_we in CALC is ignored.
- Async reset mid-CALC: drop resetn between edges -> busy, stallreq, hi, lo = 0 immediately; a new start after release completes normally.
